// File: rtl/des_sbox_layer.sv
// DES S-box substitution layer, SBOX_PER_CYCLE lookups per clock, valid/ready on both sides.
// Optional DES_SBOX_LAYER_PARITY_EN adds a registered dout_parity output.

module des_sbox_lane (
  input  logic [2:0] box,
  input  logic [5:0] seg,
  output logic [3:0] nib
);
  // TBL[b] holds S(b+1); entry {row,col} sits at nibble index row*16+col, counted from the MSB.
  localparam logic [7:0][255:0] TBL = {
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D
  };

  logic [5:0] idx;

  assign idx = {seg[5], seg[0], seg[4:1]};
  assign nib = TBL[box][255 - 4*int'(idx) -: 4];
endmodule

module des_sbox_layer #(
  parameter int SBOX_PER_CYCLE = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        din_valid,
  output logic        din_ready,
  // bit 47 is DES bit 0; S-box i+1 reads the 6-bit field starting at bit 47-6i
  input  logic [47:0] din,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [31:0] dout
`ifdef DES_SBOX_LAYER_PARITY_EN
  ,output logic       dout_parity
`endif
);
  localparam int PASSES = 8 / SBOX_PER_CYCLE;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;

  if (SBOX_PER_CYCLE != 1 && SBOX_PER_CYCLE != 2 &&
      SBOX_PER_CYCLE != 4 && SBOX_PER_CYCLE != 8) begin : g_bad_param
    $error("des_sbox_layer: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {IDLE, SUBST, HOLD} state_t;

  state_t                               state, state_nxt;
  logic [47:0]                          in_reg;
  logic [31:0]                          acc, acc_nxt;
  logic [PW-1:0]                        pass;
  logic                                 last_pass, take, give;
  logic [SBOX_PER_CYCLE-1:0][2:0]       box;
  logic [SBOX_PER_CYCLE-1:0][5:0]       seg;
  logic [SBOX_PER_CYCLE-1:0][3:0]       nib;

  assign take = din_valid & din_ready;
  assign give = dout_valid & dout_ready;

  if (PASSES == 1) begin : g_one_pass
    assign last_pass = 1'b1;
  end else begin : g_multi_pass
    assign last_pass = (pass == PW'(PASSES - 1));
  end

  // lane l serves S-box pass*P+l this cycle
  for (genvar l = 0; l < SBOX_PER_CYCLE; l++) begin : g_lane
    assign box[l] = 3'(int'(pass) * SBOX_PER_CYCLE + l);
    assign seg[l] = in_reg[47 - 6*int'(box[l]) -: 6];
    des_sbox_lane u_lane (
      .box (box[l]),
      .seg (seg[l]),
      .nib (nib[l])
    );
  end

  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < SBOX_PER_CYCLE; i++)
      acc_nxt[31 - 4*int'(box[i]) -: 4] = nib[i];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take)      state_nxt = SUBST;
      SUBST:   if (last_pass) state_nxt = HOLD;
      HOLD:    if (give)      state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    case (state)
      IDLE:    din_ready  = 1'b1;
      HOLD:    dout_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_reg <= '0;
      acc    <= '0;
      pass   <= '0;
      dout   <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          in_reg <= din;
          acc    <= '0;
          pass   <= '0;
        end
        SUBST: begin
          acc <= acc_nxt;
          if (last_pass) dout <= acc_nxt;
          else           pass <= pass + PW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef DES_SBOX_LAYER_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset_n)                      dout_parity <= 1'b0;
    else if (state == SUBST && last_pass) dout_parity <= ^acc_nxt;
  end
`endif
endmodule

// File: tb/tb_des_sbox_layer.sv
// Scoreboard bench: four DUTs (1, 2, 4, 8 S-boxes per cycle) driven in parallel, each
// checked against a table-lookup DES S-box model with a decoupled output monitor.
module tb_des_sbox_layer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  localparam int NRAND = 1000;

  typedef struct {
    logic [31:0] data;
    int          hs;
  } exp_t;

  int sbox_tbl [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  function automatic logic [31:0] des_ref(input logic [47:0] w);
    logic [31:0] r;
    int seg, row, col;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      seg = int'((w >> (42 - 6*b)) & 48'h3f);
      row = ((seg >> 5) & 1) * 2 + (seg & 1);
      col = (seg >> 1) & 15;
      r = {r[27:0], 4'(sbox_tbl[b][row][col])};
    end
    return r;
  endfunction

  function automatic void chk(input bit ok, input string name,
                              input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  for (genvar g = 0; g < 4; g++) begin : u
    localparam int P      = 1 << g;
    localparam int PASSES = 8 / P;
    localparam int K      = (PASSES - 1 < 3) ? PASSES - 1 : 3;

    logic        rst_n, din_valid, din_ready, dout_valid, dout_ready;
    logic [47:0] din;
    logic [31:0] dout;
`ifdef DES_SBOX_LAYER_PARITY_EN
    logic        dout_parity;
`endif
    int   mode;
    bit   done;
    exp_t exp_q[$];

    des_sbox_layer #(.SBOX_PER_CYCLE(P)) dut (
      .clk        (clk),
      .reset_n    (rst_n),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .din        (din),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout       (dout)
`ifdef DES_SBOX_LAYER_PARITY_EN
      ,.dout_parity (dout_parity)
`endif
    );

    task automatic step();
      @(posedge clk);
      #2;
    endtask

    task automatic send(input logic [47:0] w);
      int t;
      t = 0;
      din = w;
      din_valid = 1'b1;
      while (!din_ready && t < 64) begin
        step();
        t++;
      end
      chk(din_ready, $sformatf("p%0d_din_ready_wait", P), 64'(din_ready), 64'd1);
      if (din_ready) exp_q.push_back('{des_ref(w), cyc + 1});
      step();
      din_valid = 1'b0;
      din = 48'({$urandom, $urandom});
    endtask

    task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || !din_ready) && t < 200) begin
        step();
        t++;
      end
      chk(exp_q.size() == 0 && din_ready, $sformatf("p%0d_drain", P),
          64'(exp_q.size()), 64'd0);
    endtask

    initial begin : drv
      rst_n = 1'b0; din_valid = 1'b0; din = '0; mode = 0; done = 1'b0;
      repeat (3) step();
      chk(din_ready === 1'b1 && dout_valid === 1'b0 && dout === 32'h0,
          $sformatf("p%0d_reset", P), 64'({din_ready, dout_valid, dout}), 64'h2_0000_0000);
`ifdef DES_SBOX_LAYER_PARITY_EN
      chk(dout_parity === 1'b0, $sformatf("p%0d_reset_parity", P), 64'(dout_parity), 64'd0);
`endif
      rst_n = 1'b1;
      step();
      send(48'h0);
      send(48'hFFFF_FFFF_FFFF);
      // a second word offered while busy must not be captured
      send(48'h0123_4567_89AB);
      din = 48'hFEDC_BA98_7654;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      // downstream stalls five cycles
      mode = 2;
      send(48'({$urandom, $urandom}));
      wait_idle();
      mode = 0;
      // reset in the middle of a substitution
      send(48'({$urandom, $urandom}));
      repeat (K) step();
      rst_n = 1'b0;
      exp_q.delete();
      step();
      chk(din_ready && !dout_valid && dout == 32'h0, $sformatf("p%0d_mid_reset", P),
          64'({din_ready, dout_valid, dout}), 64'h2_0000_0000);
      rst_n = 1'b1;
      send(48'h0);
      mode = 1;
      repeat (NRAND) begin
        send(48'({$urandom, $urandom}));
        repeat ($urandom_range(0, 2)) step();
      end
      wait_idle();
      done = 1'b1;
    end

    initial begin : mon
      bit          prev_v, prev_acc, busy;
      logic [31:0] prev_dout;
      int          hcnt;
      exp_t        e;
      prev_v = 1'b0; prev_acc = 1'b0; busy = 1'b0; prev_dout = '0; hcnt = 0;
      dout_ready = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          prev_v = 1'b0; prev_acc = 1'b0; busy = 1'b0; hcnt = 0;
          dout_ready = 1'b0;
          continue;
        end
        if (busy)
          chk(!din_ready, $sformatf("p%0d_din_ready_busy", P), 64'(din_ready), 64'd0);
        if (prev_acc)
          chk(!dout_valid && din_ready, $sformatf("p%0d_after_accept", P),
              64'({dout_valid, din_ready}), 64'b01);
        if (prev_v && !prev_acc)
          chk(dout_valid && dout == prev_dout, $sformatf("p%0d_hold_stable", P),
              64'({dout_valid, dout}), 64'({1'b1, prev_dout}));
        if (dout_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, $sformatf("p%0d_unexpected_dout", P), 64'(dout), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk(dout == e.data, $sformatf("p%0d_dout", P), 64'(dout), 64'(e.data));
            chk(cyc - e.hs == PASSES, $sformatf("p%0d_latency", P),
                64'(cyc - e.hs), 64'(PASSES));
`ifdef DES_SBOX_LAYER_PARITY_EN
            chk(dout_parity == ^e.data, $sformatf("p%0d_parity", P),
                64'(dout_parity), 64'(^e.data));
`endif
          end
        end
        hcnt = dout_valid ? hcnt + 1 : 0;
        case (mode)
          0:       dout_ready = 1'b1;
          1:       dout_ready = ($urandom_range(0, 3) != 0);
          2:       dout_ready = (hcnt >= 6);
          default: dout_ready = 1'b0;
        endcase
        prev_acc = dout_valid && dout_ready;
        if (prev_acc) busy = 1'b0;
        if (din_valid && din_ready) busy = 1'b1;
        prev_v = dout_valid;
        prev_dout = dout;
      end
    end
  end

  initial begin
    fork
      wait (u[0].done && u[1].done && u[2].done && u[3].done);
      #1_500_000;
    join_any
    if (!(u[0].done && u[1].done && u[2].done && u[3].done))
      chk(1'b0, "global_timeout", 64'd0, 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
